// File: rtl/axi_rr_arbiter_2x1.sv
// Two-master to one-slave AXI arbiter with independent round-robin write (AW/W/B) and read (AR/R) paths.
// A grant is held from address acceptance until the response completes, so bursts never interleave.
module axi_rr_arbiter_2x1 #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4,
   localparam int unsigned AWP = ID_WIDTH + ADDR_WIDTH + 4 + 3 + 2,
   localparam int unsigned WP  = DATA_WIDTH + DATA_WIDTH / 8 + 1,
   localparam int unsigned RP  = DATA_WIDTH + 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       m_awvalid,
   output logic [1:0]       m_awready,
   input  logic [2*AWP-1:0] m_aw_pay,
   input  logic [1:0]       m_wvalid,
   output logic [1:0]       m_wready,
   input  logic [2*WP-1:0]  m_w_pay,
   output logic [1:0]       m_bvalid,
   input  logic [1:0]       m_bready,
   output logic [1:0]       m_bresp,
   input  logic [1:0]       m_arvalid,
   output logic [1:0]       m_arready,
   input  logic [2*AWP-1:0] m_ar_pay,
   output logic [1:0]       m_rvalid,
   input  logic [1:0]       m_rready,
   output logic [RP-1:0]    m_r_pay,
   output logic             s_awvalid,
   input  logic             s_awready,
   output logic [AWP-1:0]   s_aw_pay,
   output logic             s_wvalid,
   input  logic             s_wready,
   output logic [WP-1:0]    s_w_pay,
   input  logic             s_bvalid,
   output logic             s_bready,
   input  logic [1:0]       s_bresp,
   output logic             s_arvalid,
   input  logic             s_arready,
   output logic [AWP-1:0]   s_ar_pay,
   input  logic             s_rvalid,
   output logic             s_rready,
   input  logic [RP-1:0]    s_r_pay,
   output logic [1:0]       wr_grant,
   output logic [1:0]       rd_grant,
   output logic             wlast_err
);

   localparam int unsigned LEN_LSB = 5;

   typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ADDR = 2'd1, WR_DATA = 2'd2, WR_RESP = 2'd3} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2} rd_state_t;

   wr_state_t  wr_state, wr_state_nxt;
   rd_state_t  rd_state, rd_state_nxt;
   logic       wr_ptr, rd_ptr;
   logic [3:0] wr_len, wr_cnt;
   logic       wr_g, rd_g;
   logic       aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last_beat;

   // Winning index: a lone requester wins, on contention the master that did not go last wins.
   function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
      return (req == 2'b11) ? ~ptr : req[1];
   endfunction

   assign wr_g        = wr_grant[1];
   assign rd_g        = rd_grant[1];
   assign aw_hs       = s_awvalid & s_awready;
   assign w_hs        = s_wvalid & s_wready;
   assign b_hs        = s_bvalid & s_bready;
   assign ar_hs       = s_arvalid & s_arready;
   assign r_hs        = s_rvalid & s_rready;
   assign w_last_beat = (wr_cnt == wr_len);
   assign m_bresp     = s_bresp;
   assign m_r_pay     = s_r_pay;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wr_state <= WR_IDLE;
      else     wr_state <= wr_state_nxt;
   end

   always_comb begin
      wr_state_nxt = wr_state;
      case (wr_state)
         WR_IDLE: if (|m_awvalid)          wr_state_nxt = WR_ADDR;
         WR_ADDR: if (aw_hs)               wr_state_nxt = WR_DATA;
         WR_DATA: if (w_hs && w_last_beat) wr_state_nxt = WR_RESP;
         WR_RESP: if (b_hs)                wr_state_nxt = WR_IDLE;
         default:                          wr_state_nxt = WR_IDLE;
      endcase
   end

   // Write channel muxing driven by the registered grant.
   always_comb begin
      m_awready = 2'b00;
      m_wready  = 2'b00;
      m_bvalid  = 2'b00;
      s_awvalid = 1'b0;
      s_aw_pay  = '0;
      s_wvalid  = 1'b0;
      s_w_pay   = '0;
      s_bready  = 1'b0;
      case (wr_state)
         WR_ADDR: begin
            s_awvalid       = m_awvalid[wr_g];
            s_aw_pay        = wr_g ? m_aw_pay[2*AWP-1:AWP] : m_aw_pay[AWP-1:0];
            m_awready[wr_g] = s_awready;
         end
         WR_DATA: begin
            s_wvalid       = m_wvalid[wr_g];
            s_w_pay        = wr_g ? m_w_pay[2*WP-1:WP] : m_w_pay[WP-1:0];
            m_wready[wr_g] = s_wready;
         end
         WR_RESP: begin
            m_bvalid[wr_g] = s_bvalid;
            s_bready       = m_bready[wr_g];
         end
         default: ;
      endcase
   end

   // The burst ends on the beat count; wlast only feeds the sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_grant  <= 2'b00;
         wr_ptr    <= 1'b1;
         wr_len    <= 4'd0;
         wr_cnt    <= 4'd0;
         wlast_err <= 1'b0;
      end else begin
         case (wr_state)
            WR_IDLE: if (|m_awvalid) wr_grant <= rr_pick(m_awvalid, wr_ptr) ? 2'b10 : 2'b01;
            WR_ADDR: if (aw_hs) begin
               wr_len <= s_aw_pay[LEN_LSB +: 4];
               wr_cnt <= 4'd0;
            end
            WR_DATA: if (w_hs) begin
               wr_cnt <= wr_cnt + 4'd1;
               if (s_w_pay[0] != w_last_beat) wlast_err <= 1'b1;
            end
            WR_RESP: if (b_hs) begin
               wr_ptr   <= wr_g;
               wr_grant <= 2'b00;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_state <= RD_IDLE;
      else     rd_state <= rd_state_nxt;
   end

   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         RD_IDLE: if (|m_arvalid)     rd_state_nxt = RD_ADDR;
         RD_ADDR: if (ar_hs)          rd_state_nxt = RD_DATA;
         RD_DATA: if (r_hs && s_r_pay[0]) rd_state_nxt = RD_IDLE;
         default:                     rd_state_nxt = RD_IDLE;
      endcase
   end

   always_comb begin
      m_arready = 2'b00;
      m_rvalid  = 2'b00;
      s_arvalid = 1'b0;
      s_ar_pay  = '0;
      s_rready  = 1'b0;
      case (rd_state)
         RD_ADDR: begin
            s_arvalid       = m_arvalid[rd_g];
            s_ar_pay        = rd_g ? m_ar_pay[2*AWP-1:AWP] : m_ar_pay[AWP-1:0];
            m_arready[rd_g] = s_arready;
         end
         RD_DATA: begin
            m_rvalid[rd_g] = s_rvalid;
            s_rready       = m_rready[rd_g];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_grant <= 2'b00;
         rd_ptr   <= 1'b1;
      end else begin
         case (rd_state)
            RD_IDLE: if (|m_arvalid) rd_grant <= rr_pick(m_arvalid, rd_ptr) ? 2'b10 : 2'b01;
            RD_DATA: if (r_hs && s_r_pay[0]) begin
               rd_ptr   <= rd_g;
               rd_grant <= 2'b00;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rr_arbiter_2x1.sv
// Randomized bench for axi_rr_arbiter_2x1: the bench plays both masters and the slave,
// and predicts grants from a last-winner fairness model.
module tb_axi_rr_arbiter_2x1;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned IW  = 4;
   localparam int unsigned AWP = IW + AW + 9;
   localparam int unsigned WP  = DW + DW / 8 + 1;
   localparam int unsigned RP  = DW + 3;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready, m_bresp;
   logic [1:0] m_arvalid, m_arready, m_rvalid, m_rready;
   logic [2*AWP-1:0] m_aw_pay, m_ar_pay;
   logic [2*WP-1:0]  m_w_pay;
   logic [RP-1:0]    m_r_pay, s_r_pay;
   logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic s_arvalid, s_arready, s_rvalid, s_rready;
   logic [AWP-1:0] s_aw_pay, s_ar_pay;
   logic [WP-1:0]  s_w_pay;
   logic [1:0]     s_bresp, wr_grant, rd_grant;
   logic           wlast_err;

   int checks = 0;
   int errors = 0;
   int wr_last = 1;
   int rd_last = 1;
   logic model_wlast_err = 1'b0;

   logic [WP-1:0] wq_drive[$];
   logic [WP-1:0] wq_seen[$];
   logic [RP-1:0] rq_drive[$];
   logic [RP-1:0] rq_seen[$];
   logic [1:0]    rv_seen[$];

   logic           obs_aw_early, obs_ar_early, obs_bready_stall, obs_rready_and;
   logic [1:0]     obs_wr_grant, obs_rd_grant, obs_wready_or, obs_awready_or, obs_bvalid, obs_bresp;
   logic [1:0]     obs_wr_grant_after, obs_rd_grant_after, obs_stall_grant_or;
   logic [AWP-1:0] exp_aw_pay, exp_ar_pay, obs_s_aw_pay, obs_s_ar_pay;

   always #5 clk = ~clk;

   axi_rr_arbiter_2x1 dut (
      .clk(clk), .rst(rst),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw_pay(m_aw_pay),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w_pay(m_w_pay),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar_pay(m_ar_pay),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_r_pay(m_r_pay),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw_pay(s_aw_pay),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w_pay(s_w_pay),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar_pay(s_ar_pay),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r_pay(s_r_pay),
      .wr_grant(wr_grant), .rd_grant(rd_grant), .wlast_err(wlast_err)
   );

   function automatic logic [1:0] oh(input int m);
      return (m == 1) ? 2'b10 : 2'b01;
   endfunction

   // Fairness rule: a lone requester wins; with both requesting, the one that did not finish last wins.
   function automatic int model_winner(input logic [1:0] req, input int last);
      if (req == 2'b11) return 1 - last;
      return (req == 2'b10) ? 1 : 0;
   endfunction

   function automatic logic [AWP-1:0] rand_pay();
      return AWP'({$urandom, $urandom});
   endfunction

   function automatic int w_diffs();
      int d;
      if (wq_seen.size() != wq_drive.size()) return 100;
      d = 0;
      foreach (wq_seen[i]) if (wq_seen[i] !== wq_drive[i]) d++;
      return d;
   endfunction

   function automatic int r_diffs(input int m);
      int d;
      if (rq_seen.size() != rq_drive.size() || rv_seen.size() != rq_drive.size()) return 100;
      d = 0;
      foreach (rq_seen[i]) if (rq_seen[i] !== rq_drive[i] || rv_seen[i] !== oh(m)) d++;
      return d;
   endfunction

   // Master m write of len+1 beats against an always-ready slave; starts and ends just after a negedge.
   task automatic wr_txn(input int m, input logic [3:0] len, input logic [AW-1:0] addr,
                         input int bad_beat, input int bstall, input logic [1:0] resp);
      logic wl;
      exp_aw_pay = {IW'($urandom), addr, len, 3'd2, 2'b01};
      m_aw_pay[m*AWP +: AWP] = exp_aw_pay;
      m_awvalid[m] = 1'b1;
      wq_drive.delete();
      wq_seen.delete();
      for (int i = 0; i <= int'(len); i++) begin
         wl = (i == int'(len)) ^ (i == bad_beat);
         wq_drive.push_back({DW'($urandom), 4'($urandom), wl});
      end
      #1;
      obs_aw_early = s_awvalid;
      @(negedge clk); #1;
      obs_wr_grant = wr_grant;
      obs_s_aw_pay = s_aw_pay;
      @(negedge clk);
      m_awvalid[m]   = 1'b0;
      obs_wready_or  = 2'b00;
      obs_awready_or = 2'b00;
      for (int i = 0; i < wq_drive.size(); i++) begin
         m_wvalid[m] = 1'b1;
         m_w_pay[m*WP +: WP] = wq_drive[i];
         #1;
         if (s_wvalid) wq_seen.push_back(s_w_pay);
         obs_wready_or  = obs_wready_or | m_wready;
         obs_awready_or = obs_awready_or | m_awready;
         @(negedge clk);
      end
      m_wvalid[m] = 1'b0;
      m_bready[m] = (bstall == 0);
      s_bvalid = 1'b1;
      s_bresp  = resp;
      obs_bready_stall   = 1'b0;
      obs_stall_grant_or = 2'b00;
      for (int i = 0; i < bstall; i++) begin
         #1;
         obs_bready_stall   = obs_bready_stall | s_bready;
         obs_stall_grant_or = obs_stall_grant_or | wr_grant;
         obs_awready_or     = obs_awready_or | m_awready;
         @(negedge clk);
      end
      m_bready[m] = 1'b1;
      #1;
      obs_bvalid = m_bvalid;
      obs_bresp  = m_bresp;
      @(negedge clk);
      s_bvalid = 1'b0;
      m_bready[m] = 1'b0;
      #1;
      obs_wr_grant_after = wr_grant;
   endtask

   // Master m read of len+1 beats; the slave sets rlast on the final beat.
   task automatic rd_txn(input int m, input logic [3:0] len, input logic [AW-1:0] addr);
      logic rl;
      exp_ar_pay = {IW'($urandom), addr, len, 3'd2, 2'b01};
      m_ar_pay[m*AWP +: AWP] = exp_ar_pay;
      m_arvalid[m] = 1'b1;
      rq_drive.delete();
      rq_seen.delete();
      rv_seen.delete();
      for (int i = 0; i <= int'(len); i++) begin
         rl = (i == int'(len));
         rq_drive.push_back({DW'($urandom), 2'($urandom), rl});
      end
      #1;
      obs_ar_early = s_arvalid;
      @(negedge clk); #1;
      obs_rd_grant = rd_grant;
      obs_s_ar_pay = s_ar_pay;
      @(negedge clk);
      m_arvalid[m]   = 1'b0;
      m_rready[m]    = 1'b1;
      obs_rready_and = 1'b1;
      for (int i = 0; i < rq_drive.size(); i++) begin
         s_rvalid = 1'b1;
         s_r_pay  = rq_drive[i];
         #1;
         rv_seen.push_back(m_rvalid);
         rq_seen.push_back(m_r_pay);
         obs_rready_and = obs_rready_and & s_rready;
         @(negedge clk);
      end
      s_rvalid = 1'b0;
      m_rready[m] = 1'b0;
      #1;
      obs_rd_grant_after = rd_grant;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_awvalid = 2'b11; m_arvalid = 2'b11; m_wvalid = 2'b11;
      m_bready = 2'b11; m_rready = 2'b11; s_bvalid = 1'b1; s_rvalid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({m_awready, m_wready, m_bvalid, m_arready, m_rvalid} !== 10'd0) begin
         errors++;
         $display("FAIL reset_master_side got=%b want=0", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid});
      end
      checks++;
      if ({s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} !== 5'd0) begin
         errors++;
         $display("FAIL reset_slave_side got=%b want=0", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready});
      end
      checks++;
      if ({wr_grant, rd_grant, wlast_err} !== 5'd0) begin
         errors++;
         $display("FAIL reset_grants got=%b want=0", {wr_grant, rd_grant, wlast_err});
      end
      @(negedge clk);
      m_awvalid = 2'b00; m_arvalid = 2'b00; m_wvalid = 2'b00;
      m_bready = 2'b00; m_rready = 2'b00; s_bvalid = 1'b0; s_rvalid = 1'b0;
      rst = 1'b0;
      wr_last = 1; rd_last = 1; model_wlast_err = 1'b0;
   endtask

   task automatic test_single_write();
      logic [1:0] resp;
      int w;
      resp = 2'($urandom);
      w = model_winner(2'b01, wr_last);
      wr_txn(0, 4'd3, 32'h10, -1, 0, resp);
      wr_last = w;
      checks++;
      if (obs_aw_early !== 1'b0) begin errors++; $display("FAIL single_arb_latency s_awvalid=%b want=0", obs_aw_early); end
      checks++;
      if (obs_wr_grant !== oh(w)) begin errors++; $display("FAIL single_grant got=%b want=%b", obs_wr_grant, oh(w)); end
      checks++;
      if (obs_s_aw_pay !== exp_aw_pay) begin errors++; $display("FAIL single_aw_pay got=%h want=%h", obs_s_aw_pay, exp_aw_pay); end
      checks++;
      if (w_diffs() !== 0) begin errors++; $display("FAIL single_w_beats diffs=%0d want=0", w_diffs()); end
      checks++;
      if (obs_wready_or !== oh(w)) begin errors++; $display("FAIL single_wready got=%b want=%b", obs_wready_or, oh(w)); end
      checks++;
      if ({obs_bvalid, obs_bresp} !== {oh(w), resp}) begin
         errors++; $display("FAIL single_b got=%b/%b want=%b/%b", obs_bvalid, obs_bresp, oh(w), resp);
      end
      checks++;
      if (obs_wr_grant_after !== 2'b00) begin errors++; $display("FAIL single_grant_release got=%b want=00", obs_wr_grant_after); end
   endtask

   task automatic test_contention();
      int w;
      for (int k = 0; k < 4; k++) begin
         w = model_winner(2'b11, wr_last);
         m_aw_pay[(1-w)*AWP +: AWP] = rand_pay();
         m_awvalid = 2'b11;
         wr_txn(w, 4'($urandom_range(1, 5)), AW'($urandom), -1, 0, 2'b00);
         wr_last = w;
         checks++;
         if (obs_wr_grant !== oh(w)) begin errors++; $display("FAIL contention_grant[%0d] got=%b want=%b", k, obs_wr_grant, oh(w)); end
         checks++;
         if (obs_awready_or !== 2'b00) begin errors++; $display("FAIL contention_loser_ready[%0d] got=%b want=00", k, obs_awready_or); end
         checks++;
         if (w_diffs() !== 0) begin errors++; $display("FAIL contention_w_beats[%0d] diffs=%0d want=0", k, w_diffs()); end
      end
      m_awvalid = 2'b00;
   endtask

   task automatic test_concurrent();
      fork
         wr_txn(1, 4'd7, AW'($urandom), -1, 0, 2'b00);
         rd_txn(0, 4'd3, 32'h10);
      join
      wr_last = 1;
      rd_last = 0;
      checks++;
      if ({obs_wr_grant, obs_rd_grant} !== 4'b1001) begin
         errors++; $display("FAIL concurrent_grants got=%b/%b want=10/01", obs_wr_grant, obs_rd_grant);
      end
      checks++;
      if (obs_ar_early !== 1'b0) begin errors++; $display("FAIL concurrent_ar_latency s_arvalid=%b want=0", obs_ar_early); end
      checks++;
      if (obs_s_ar_pay !== exp_ar_pay) begin errors++; $display("FAIL concurrent_ar_pay got=%h want=%h", obs_s_ar_pay, exp_ar_pay); end
      checks++;
      if (w_diffs() !== 0) begin errors++; $display("FAIL concurrent_w_beats diffs=%0d want=0", w_diffs()); end
      checks++;
      if (r_diffs(0) !== 0) begin errors++; $display("FAIL concurrent_r_beats diffs=%0d want=0", r_diffs(0)); end
      checks++;
      if (obs_rready_and !== 1'b1) begin errors++; $display("FAIL concurrent_rready got=%b want=1", obs_rready_and); end
      checks++;
      if ({obs_wr_grant_after, obs_rd_grant_after} !== 4'b0000) begin
         errors++; $display("FAIL concurrent_release got=%b/%b want=00/00", obs_wr_grant_after, obs_rd_grant_after);
      end
   endtask

   task automatic test_wlast_err();
      checks++;
      if (wlast_err !== model_wlast_err) begin errors++; $display("FAIL wlast_err_before got=%b want=%b", wlast_err, model_wlast_err); end
      wr_txn(1, 4'd3, AW'($urandom), 2, 0, 2'b10);
      wr_last = 1;
      model_wlast_err = 1'b1;
      checks++;
      if (wlast_err !== model_wlast_err) begin errors++; $display("FAIL wlast_err_set got=%b want=%b", wlast_err, model_wlast_err); end
      checks++;
      if (w_diffs() !== 0) begin errors++; $display("FAIL wlast_err_beats diffs=%0d want=0", w_diffs()); end
      checks++;
      if ({obs_bvalid, obs_bresp} !== 4'b1010) begin errors++; $display("FAIL wlast_err_b got=%b/%b want=10/10", obs_bvalid, obs_bresp); end
      wr_txn(1, 4'd1, AW'($urandom), -1, 0, 2'b00);
      wr_last = 1;
      checks++;
      if (wlast_err !== model_wlast_err) begin errors++; $display("FAIL wlast_err_sticky got=%b want=%b", wlast_err, model_wlast_err); end
   endtask

   task automatic test_backpressure();
      int w;
      w = model_winner(2'b11, wr_last);
      m_aw_pay[(1-w)*AWP +: AWP] = rand_pay();
      m_awvalid = 2'b11;
      wr_txn(w, 4'd1, AW'($urandom), -1, 5, 2'b01);
      wr_last = w;
      checks++;
      if (obs_bready_stall !== 1'b0) begin errors++; $display("FAIL bp_s_bready got=%b want=0", obs_bready_stall); end
      checks++;
      if (obs_stall_grant_or !== oh(w)) begin errors++; $display("FAIL bp_grant_held got=%b want=%b", obs_stall_grant_or, oh(w)); end
      checks++;
      if (obs_awready_or !== 2'b00) begin errors++; $display("FAIL bp_no_new_aw got=%b want=00", obs_awready_or); end
      checks++;
      if ({obs_bvalid, obs_bresp} !== {oh(w), 2'b01}) begin
         errors++; $display("FAIL bp_b got=%b/%b want=%b/01", obs_bvalid, obs_bresp, oh(w));
      end
      w = model_winner(oh(1 - w), wr_last);
      wr_txn(w, 4'd0, AW'($urandom), -1, 0, 2'b00);
      wr_last = w;
      checks++;
      if (obs_wr_grant !== oh(w)) begin errors++; $display("FAIL bp_waiter_grant got=%b want=%b", obs_wr_grant, oh(w)); end
   endtask

   task automatic test_reset_mid();
      wr_txn(0, 4'd0, AW'($urandom), -1, 0, 2'b00);
      wr_last = 0;
      m_aw_pay[AWP +: AWP] = {IW'(1), AW'($urandom), 4'd3, 3'd2, 2'b01};
      m_awvalid[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m_awvalid[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_wvalid[1] = 1'b1;
         m_w_pay[WP +: WP] = {DW'($urandom), 4'hf, 1'b0};
         if (i < 2) @(negedge clk);
      end
      #1;
      checks++;
      if ({wr_grant, s_wvalid} !== 3'b101) begin errors++; $display("FAIL mid_before_rst got=%b want=101", {wr_grant, s_wvalid}); end
      rst = 1'b1;
      #1;
      checks++;
      if ({s_wvalid, m_wready, wr_grant, s_awvalid, m_awready} !== 8'd0) begin
         errors++; $display("FAIL mid_async_clear got=%b want=0", {s_wvalid, m_wready, wr_grant, s_awvalid, m_awready});
      end
      checks++;
      if (wlast_err !== 1'b0) begin errors++; $display("FAIL mid_wlast_err_clear got=%b want=0", wlast_err); end
      m_wvalid = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      wr_last = 1; rd_last = 1; model_wlast_err = 1'b0;
      m_aw_pay[AWP +: AWP] = rand_pay();
      m_awvalid = 2'b11;
      wr_txn(model_winner(2'b11, wr_last), 4'd2, AW'($urandom), -1, 0, 2'b00);
      checks++;
      if (obs_wr_grant !== oh(model_winner(2'b11, wr_last))) begin
         errors++; $display("FAIL mid_post_rst_winner got=%b want=%b", obs_wr_grant, oh(model_winner(2'b11, wr_last)));
      end
      wr_last = model_winner(2'b11, wr_last);
      m_awvalid = 2'b00;
   endtask

   task automatic test_random();
      logic [1:0] req, resp;
      logic [3:0] len;
      int w;
      for (int k = 0; k < 12; k++) begin
         req  = 2'($urandom_range(1, 3));
         len  = 4'($urandom_range(0, 7));
         resp = 2'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            w = model_winner(req, wr_last);
            m_aw_pay[(1-w)*AWP +: AWP] = rand_pay();
            m_awvalid = req;
            wr_txn(w, len, AW'($urandom), -1, 0, resp);
            m_awvalid = 2'b00;
            wr_last = w;
            checks++;
            if (obs_wr_grant !== oh(w) || obs_s_aw_pay !== exp_aw_pay) begin
               errors++; $display("FAIL rand_wr_addr[%0d] grant=%b pay=%h want=%b/%h", k, obs_wr_grant, obs_s_aw_pay, oh(w), exp_aw_pay);
            end
            checks++;
            if (w_diffs() !== 0 || obs_bvalid !== oh(w) || obs_bresp !== resp) begin
               errors++; $display("FAIL rand_wr_data[%0d] diffs=%0d b=%b/%b want=0/%b/%b", k, w_diffs(), obs_bvalid, obs_bresp, oh(w), resp);
            end
         end else begin
            w = model_winner(req, rd_last);
            m_ar_pay[(1-w)*AWP +: AWP] = rand_pay();
            m_arvalid = req;
            rd_txn(w, len, AW'($urandom));
            m_arvalid = 2'b00;
            rd_last = w;
            checks++;
            if (obs_rd_grant !== oh(w) || obs_s_ar_pay !== exp_ar_pay) begin
               errors++; $display("FAIL rand_rd_addr[%0d] grant=%b pay=%h want=%b/%h", k, obs_rd_grant, obs_s_ar_pay, oh(w), exp_ar_pay);
            end
            checks++;
            if (r_diffs(w) !== 0 || obs_rd_grant_after !== 2'b00) begin
               errors++; $display("FAIL rand_rd_data[%0d] diffs=%0d after=%b want=0/00", k, r_diffs(w), obs_rd_grant_after);
            end
         end
      end
      checks++;
      if (wlast_err !== model_wlast_err) begin errors++; $display("FAIL rand_wlast_err got=%b want=%b", wlast_err, model_wlast_err); end
   endtask

   initial begin
      rst = 1'b1;
      m_awvalid = 2'b00; m_wvalid = 2'b00; m_bready = 2'b00;
      m_arvalid = 2'b00; m_rready = 2'b00;
      m_aw_pay = '0; m_w_pay = '0; m_ar_pay = '0;
      s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
      s_bvalid = 1'b0; s_bresp = 2'b00; s_rvalid = 1'b0; s_r_pay = '0;
      test_reset();
      test_single_write();
      test_contention();
      test_concurrent();
      test_wlast_err();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
